// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   DEF_W / DEF_DIGITS : default operand width and digit count (5 digits cover 16 bits)
//   state_t            : FSM state encoding
//   cnt_width()        : width of the bit counter for a given operand width
package bin_to_bcd_seq_pkg;

    localparam int DEF_W      = 16;
    localparam int DEF_DIGITS = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The counter must hold W-1; never let it collapse to zero bits.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bus of the binary-to-BCD converter.
//   start    : request a conversion of bin (taken only while busy=0)
//   bin      : binary operand, W bits
//   busy     : conversion in progress
//   done     : one-cycle result strobe
//   bcd      : 4*DIGITS-bit result, digit 0 in [3:0]
//   digit_on : per-digit significance mask, bit 0 always set
//   overflow : value did not fit in DIGITS digits
// master = requester (drives start/bin), slave = converter.
interface bin_to_bcd_seq_if #(
    parameter int W      = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [W-1:0]          bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     digit_on;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, digit_on, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, digit_on, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq_nibble_adjust.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is >= 5,
// so that the following left shift carries correctly into the next digit.
//   nib_i : current digit
//   nib_o : corrected digit (at most 12, so no carry out of the nibble)
module bcd_nibble_adjust (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one operand bit per clock).
// A conversion takes W+1 clocks from the accepting edge to the done pulse;
// back-to-back conversions repeat every W+2 clocks.
//   clk      : system clock
//   reset    : synchronous, active-high; abandons any conversion in flight
//   bus      : slave side of bin_to_bcd_seq_if (start/bin in, busy/done/bcd/
//              digit_on/overflow out, all outputs registered)
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic            clk,
    input  logic            reset,
    bin_to_bcd_seq_if.slave bus
);

    localparam int CNT_W = cnt_width(W);
    localparam int ACC_W = 4 * DIGITS;

    state_t              state_q;
    logic [W-1:0]        shift_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;

    logic                busy_q;
    logic                done_q;
    logic [ACC_W-1:0]    bcd_q;
    logic [DIGITS-1:0]   digit_on_q;
    logic                overflow_q;

    logic [ACC_W-1:0]    adj;
    logic [ACC_W-1:0]    acc_d;
    logic [W-1:0]        shift_d;

    // Digit i is significant when it or any higher digit is non-zero;
    // the units digit is always shown so zero displays as "0".
    function automatic logic [DIGITS-1:0] sig_digits(input logic [ACC_W-1:0] v);
        logic [DIGITS-1:0] m;
        logic              any;
        any = 1'b0;
        m   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any  = any | (v[4*i +: 4] != 4'd0);
            m[i] = any;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .nib_i (acc_q[4*gi +: 4]),
            .nib_o (adj[4*gi +: 4])
        );
    end

    // Shift the corrected accumulator and the operand as one long register.
    // The bit falling off the top digit is lost from the result and is
    // recorded as overflow instead (result then equals value mod 10^DIGITS).
    assign {acc_d, shift_d} = {adj, shift_q} << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            digit_on_q <= DIGITS'(1);
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        shift_q <= bus.bin;
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(W - 1);
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    acc_q   <= acc_d;
                    shift_q <= shift_d;
                    ovf_q   <= ovf_q | adj[ACC_W-1];
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_q      <= acc_q;
                    overflow_q <= ovf_q;
                    digit_on_q <= sig_digits(acc_q);
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.digit_on = digit_on_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    localparam int W = 16;

    typedef struct {
        logic [19:0] bcd;
        logic [4:0]  on;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic hold_mode = 1'b0;
    int   last5 = -1;
    int   gap = 0;
    exp_t q5[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.W(W), .DIGITS(5)) bus5 ();
    bin_to_bcd_seq_if #(.W(W), .DIGITS(4)) bus4 ();

    bin_to_bcd_seq #(.W(W), .DIGITS(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5));
    bin_to_bcd_seq #(.W(W), .DIGITS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: decimal digits by div/mod, modulo 10^digits.
    function automatic exp_t model(input int b, input int digits, input int c);
        exp_t e;
        int   p;
        int   m;
        int   v;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        m     = b % p;
        e.ovf = (b >= p);
        e.bcd = '0;
        e.on  = '0;
        v     = m;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        p = 1;
        for (int i = 0; i < digits; i++) begin
            e.on[i] = (i == 0) || (m >= p);
            p = p * 10;
        end
        e.cyc = c;
        return e;
    endfunction

    // Acceptance: start seen while idle pushes the expected result.
    always @(posedge clk) begin
        if (reset) begin
            q5.delete();
            q4.delete();
        end else begin
            if (bus5.start && !bus5.busy) q5.push_back(model(int'(bus5.bin), 5, cyc));
            if (bus4.start && !bus4.busy) q4.push_back(model(int'(bus4.bin), 4, cyc));
        end
        cyc++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus5.done) begin
            chk("done_while_busy5", 32'(bus5.busy), 0);
            if (q5.size() == 0) chk("unexpected_done5", 1, 0);
            else begin
                e = q5.pop_front();
                chk("bcd5", 32'(bus5.bcd), 32'(e.bcd));
                chk("digit_on5", 32'(bus5.digit_on), 32'(e.on));
                chk("overflow5", 32'(bus5.overflow), 32'(e.ovf));
                chk("latency5", 32'(cyc - 1 - e.cyc), W + 1);
            end
            if (hold_mode && last5 >= 0) chk("period5", 32'(cyc - last5), W + 2);
            last5 = cyc;
        end
        if (bus4.done) begin
            if (q4.size() == 0) chk("unexpected_done4", 1, 0);
            else begin
                e = q4.pop_front();
                chk("bcd4", 32'(bus4.bcd), 32'(e.bcd[15:0]));
                chk("digit_on4", 32'(bus4.digit_on), 32'(e.on[3:0]));
                chk("overflow4", 32'(bus4.overflow), 32'(e.ovf));
                chk("latency4", 32'(cyc - 1 - e.cyc), W + 1);
            end
        end
        if (hold_mode) begin
            if (!bus5.busy) gap++;
            else begin
                if (gap > 0) chk("busy_gap", 32'(gap), 1);
                gap = 0;
            end
        end
    end

    task automatic drive(input logic s, input logic [15:0] b);
        bus5.start = s;
        bus4.start = s;
        bus5.bin   = b;
        bus4.bin   = b;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!bus5.busy && !bus4.busy) return;
            @(negedge clk);
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus5.done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 1);
    endtask

    // Called at a negedge; returns at the negedge where done is visible.
    task automatic run_conv(input logic [15:0] b);
        wait_idle();
        drive(1'b1, b);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 16'($urandom));
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus5.busy), 0);
        chk({tag, "_done"}, 32'(bus5.done), 0);
        chk({tag, "_bcd"}, 32'(bus5.bcd), 0);
        chk({tag, "_digit_on"}, 32'(bus5.digit_on), 1);
        chk({tag, "_overflow"}, 32'(bus5.overflow), 0);
        chk({tag, "_bcd4"}, 32'(bus4.bcd), 0);
        chk({tag, "_overflow4"}, 32'(bus4.overflow), 0);
    endtask

    initial begin
        int n;
        drive(1'b0, 16'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("rst");

        // Zero, full scale, mid value.
        run_conv(16'd0);
        run_conv(16'd65535);
        run_conv(16'd1234);
        run_conv(16'd9999);
        run_conv(16'd10000);

        // Second start while busy is dropped.
        wait_idle();
        drive(1'b1, 16'd999);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 16'd0);
        repeat (4) @(negedge clk);
        drive(1'b1, 16'd7);
        @(negedge clk);
        drive(1'b0, 16'd7);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus5.done) n++;
        end
        chk("ignored_start_dones", 32'(n), 1);

        // start held high: continuous conversions every W+2 clocks.
        wait_idle();
        last5     = -1;
        gap       = 0;
        hold_mode = 1'b1;
        drive(1'b1, 16'd42);
        n = 0;
        for (int i = 0; i < 100 && n < 3; i++) begin
            @(negedge clk);
            if (bus5.done) n++;
        end
        drive(1'b0, 16'd42);
        hold_mode = 1'b0;
        chk("hold_dones", 32'(n), 3);
        @(negedge clk);

        // Overflow in the 4-digit instance, then cleared by a small value.
        run_conv(16'd12345);
        chk("ovf4_set", 32'(bus4.overflow), 1);
        run_conv(16'd99);
        chk("ovf4_clear", 32'(bus4.overflow), 0);
        run_conv(16'd12345);

        // Reset in the middle of a conversion.
        wait_idle();
        drive(1'b1, 16'd4321);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 16'd0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("midrst");
        n = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus5.done || bus4.done) n++;
        end
        chk("midrst_no_done", 32'(n), 0);
        run_conv(16'd321);

        for (int i = 0; i < 1000; i++) begin
            run_conv(16'($urandom_range(0, 65535)));
        end

        repeat (3) @(negedge clk);
        chk("q5_empty", 32'(q5.size()), 0);
        chk("q4_empty", 32'(q4.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
